// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// the hardwired zero register index and the mul/div counter width.
package pipe_ctrl_pkg;

   typedef enum logic {
      StRun    = 1'b0,
      StMdBusy = 1'b1
   } hazard_state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam int unsigned CntW = 4;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: a load in EX writes a register that the
// instruction in ID is about to read.
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rt,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   output logic       load_use
);

   // Writes to r0 are discarded, so a load into r0 can never feed a consumer.
   assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage pipeline: jump flush, load-use bubble and
// multi-cycle mul/div hold. Define HAZARD_STATS_EN to add the StallCount port.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MD_LATENCY = 4
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic [4:0] ID_rs,
   input  logic [4:0] ID_rt,
   input  logic       ID_UsesRt,
   input  logic       EX_MemRead,
   input  logic [4:0] EX_rt,
   input  logic       EX_Jump,
   input  logic       EX_MulDiv,
   output logic       PCWrite,
   output logic       IF_ID_Write,
   output logic       IF_ID_Flush,
   output logic       ID_EX_Bubble,
   output logic       EX_Hold,
   output logic       State
`ifdef HAZARD_STATS_EN
   ,
   output logic [15:0] StallCount
`endif
);

   hazard_state_e   state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            load_use;

   load_use_detect u_load_use_detect (
      .ex_mem_read (EX_MemRead),
      .ex_rt       (EX_rt),
      .id_rs       (ID_rs),
      .id_rt       (ID_rt),
      .id_uses_rt  (ID_UsesRt),
      .load_use    (load_use)
   );

   always_comb begin
      PCWrite      = 1'b1;
      IF_ID_Write  = 1'b1;
      IF_ID_Flush  = 1'b0;
      ID_EX_Bubble = 1'b0;
      EX_Hold      = 1'b0;
      state_d      = state_q;
      cnt_d        = cnt_q;
      if (Rst_n) begin
         unique case (state_q)
            StRun: begin
               if (EX_Jump) begin
                  IF_ID_Flush  = 1'b1;
                  ID_EX_Bubble = 1'b1;
               end else if (EX_MulDiv) begin
                  PCWrite     = 1'b0;
                  IF_ID_Write = 1'b0;
                  EX_Hold     = 1'b1;
                  // The entry cycle counts toward the hold, so load latency-2.
                  cnt_d       = CntW'(MD_LATENCY - 2);
                  state_d     = StMdBusy;
               end else if (load_use) begin
                  PCWrite      = 1'b0;
                  IF_ID_Write  = 1'b0;
                  ID_EX_Bubble = 1'b1;
               end
            end
            StMdBusy: begin
               if (cnt_q != '0) begin
                  PCWrite     = 1'b0;
                  IF_ID_Write = 1'b0;
                  EX_Hold     = 1'b1;
                  cnt_d       = cnt_q - CntW'(1);
               end else begin
                  state_d = StRun;
               end
            end
            default: state_d = StRun;
         endcase
      end
   end

   assign State = Rst_n ? logic'(state_q) : 1'b0;

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q <= StRun;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZARD_STATS_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         stall_cnt_q <= '0;
      end else if (!PCWrite && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl at MD_LATENCY=4.
// Output vector order: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold, State}.
module tb_pipeline_hazard_ctrl;

   logic       Clk = 1'b0;
   logic       Rst_n;
   logic [4:0] ID_rs, ID_rt, EX_rt;
   logic       ID_UsesRt, EX_MemRead, EX_Jump, EX_MulDiv;
   logic       PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold, State;
`ifdef HAZARD_STATS_EN
   logic [15:0] StallCount;
`endif

   int compared = 0;
   int mismatched = 0;
   logic [5:0] obs;

   assign obs = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_Hold, State};

   always #5 Clk = ~Clk;

   pipeline_hazard_ctrl #(.MD_LATENCY(4)) dut (
      .Clk          (Clk),
      .Rst_n        (Rst_n),
      .ID_rs        (ID_rs),
      .ID_rt        (ID_rt),
      .ID_UsesRt    (ID_UsesRt),
      .EX_MemRead   (EX_MemRead),
      .EX_rt        (EX_rt),
      .EX_Jump      (EX_Jump),
      .EX_MulDiv    (EX_MulDiv),
      .PCWrite      (PCWrite),
      .IF_ID_Write  (IF_ID_Write),
      .IF_ID_Flush  (IF_ID_Flush),
      .ID_EX_Bubble (ID_EX_Bubble),
      .EX_Hold      (EX_Hold),
      .State        (State)
`ifdef HAZARD_STATS_EN
      ,
      .StallCount   (StallCount)
`endif
   );

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                        input logic mr, input logic [4:0] ert, input logic j, input logic md);
      ID_rs = rs; ID_rt = rt; ID_UsesRt = uses_rt;
      EX_MemRead = mr; EX_rt = ert; EX_Jump = j; EX_MulDiv = md;
   endtask

   // Sample mid-cycle, then advance to just after the next rising edge.
   task automatic chk(input string tag, input logic [5:0] exp, input logic [5:0] mask);
      @(negedge Clk);
      compared++;
      assert ((obs & mask) === (exp & mask)) else begin
         mismatched++;
         $error("FAIL %s: observed %b expected %b (mask %b)", tag, obs, exp, mask);
      end
      @(posedge Clk); #1;
   endtask

`ifdef HAZARD_STATS_EN
   task automatic chk_cnt(input string tag, input logic [15:0] exp);
      @(negedge Clk);
      compared++;
      assert (StallCount === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, StallCount, exp);
      end
      @(posedge Clk); #1;
   endtask
`endif

   localparam logic [5:0] ALL = 6'b111111;
   localparam logic [5:0] NO_IFW = 6'b101111;
   localparam logic [5:0] NO_FLUSH = 6'b110111;
   localparam logic [5:0] NO_FB = 6'b110011;

   initial begin
      Rst_n = 1'b0;
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      chk("reset_idle", 6'b110000, ALL);
      drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1);
      chk("reset_overrides_inputs", 6'b110000, ALL);
      Rst_n = 1'b1;
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      chk("run_idle", 6'b110000, ALL);

      drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
      chk("load_use_rs", 6'b000100, ALL);
      drive(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0);
      chk("after_bubble", 6'b110000, ALL);
      drive(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
      chk("load_use_rt", 6'b000100, ALL);
      drive(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
      chk("zero_reg_no_stall", 6'b110000, ALL);
      drive(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
      chk("rt_unused_no_stall", 6'b110000, ALL);

      drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
      chk("jump_beats_load_use", 6'b101100, NO_IFW);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
      chk("jump_beats_muldiv", 6'b101100, NO_IFW);

      // Mul/div with a simultaneous load-use: hold wins, no bubble.
      drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1);
      chk("md_enter", 6'b000010, NO_FLUSH);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      chk("md_busy_cnt2", 6'b000011, NO_FB);
      drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1);
      chk("md_busy_cnt1_ignores", 6'b000011, NO_FB);
      chk("md_release", 6'b110001, ALL);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      chk("md_back_to_run", 6'b110000, ALL);

      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      chk("md2_enter", 6'b000010, NO_FLUSH);
      chk("md2_busy_cnt2", 6'b000011, NO_FB);
      Rst_n = 1'b0;
      chk("md2_reset_at_cnt1", 6'b110000, ALL);
      Rst_n = 1'b1;
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      chk("after_mid_busy_reset", 6'b110000, ALL);

`ifdef HAZARD_STATS_EN
      chk_cnt("stats_after_reset", 16'd0);
      drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
      chk("stats_load_use", 6'b000100, ALL);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      chk("stats_md_enter", 6'b000010, NO_FLUSH);
      chk("stats_md_cnt2", 6'b000011, NO_FB);
      chk("stats_md_cnt1", 6'b000011, NO_FB);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      chk("stats_md_release", 6'b110001, ALL);
      chk_cnt("stats_four", 16'd4);
      drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
      begin
         int n = 0;
         while (StallCount !== 16'hFFFF && n < 70000) begin
            @(posedge Clk); #1;
            n++;
         end
      end
      chk_cnt("stats_reaches_max", 16'hFFFF);
      chk_cnt("stats_saturates", 16'hFFFF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_LATENCY, default 4, legal range 2..16: total cycles a mul/div instruction occupies EX.
REQ-002 SHALL have port Clk  in  1  single clock; all state updates on posedge Clk.
REQ-003 SHALL have port Rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port ID_rs  in  5  rs field of the instruction in ID.
REQ-005 SHALL have port ID_rt  in  5  rt field of the instruction in ID.
REQ-006 SHALL have port ID_UsesRt  in  1  the instruction in ID reads rt as a source.
REQ-007 SHALL have port EX_MemRead  in  1  MemRead control currently held in ID/EX.
REQ-008 SHALL have port EX_rt  in  5  rt currently held in ID/EX.
REQ-009 SHALL have port EX_Jump  in  1  taken jump or jr currently in EX.
REQ-010 SHALL have port EX_MulDiv  in  1  multi-cycle mul/div currently in EX.
REQ-011 SHALL have port PCWrite  out  1  PC may update.
REQ-012 SHALL have port IF_ID_Write  out  1  IF/ID may load.
REQ-013 SHALL have port IF_ID_Flush  out  1  IF/ID loads a NOP.
REQ-014 SHALL have port ID_EX_Bubble  out  1  ID/EX loads all-zero control signals.
REQ-015 SHALL have port EX_Hold  out  1  ID/EX and EX/MEM keep their contents.
REQ-016 SHALL have port State  out  1  0=RUN, 1=MD_BUSY, for debug.

Function
REQ-017 SHALL compute all outputs combinationally from the current state and inputs (Mealy), with no added latency.
REQ-018 SHALL detect load-use as: EX_MemRead=1 and EX_rt!=0 and (EX_rt==ID_rs or (ID_UsesRt=1 and EX_rt==ID_rt)).
REQ-019 SHALL evaluate conditions in RUN with priority EX_Jump > EX_MulDiv > load-use > none.
REQ-020 SHALL, for RUN with no condition active, drive PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Bubble=0, EX_Hold=0.
REQ-021 SHALL, for RUN with EX_Jump=1, drive PCWrite=1, IF_ID_Flush=1, ID_EX_Bubble=1, EX_Hold=0, and remain in RUN.
REQ-022 SHALL, for RUN with load-use, drive PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, EX_Hold=0, and remain in RUN; the inserted bubble clears the hazard on the next cycle.
REQ-023 SHALL, for RUN with EX_MulDiv=1, drive PCWrite=0, IF_ID_Write=0, EX_Hold=1, ID_EX_Bubble=0, load cnt<=MD_LATENCY-2, and move to MD_BUSY.
REQ-024 SHALL, in MD_BUSY with cnt!=0, drive PCWrite=0, IF_ID_Write=0, EX_Hold=1, and decrement cnt.
REQ-025 SHALL, in MD_BUSY with cnt==0, drive all outputs as in REQ-020 and return to RUN; the mul/div is then held for exactly MD_LATENCY-1 cycles.
REQ-026 SHALL ignore EX_Jump, EX_MulDiv and load-use while in MD_BUSY.
REQ-027 SHALL size cnt at 4 bits and never let it wrap below 0.

Reset
REQ-028 SHALL, when Rst_n=0 at a posedge, set state=RUN and cnt=0 (and StallCount=0 when compiled in), including mid-MD_BUSY.
REQ-029 SHALL drive PCWrite=1, IF_ID_Write=1, and all other outputs 0 while Rst_n=0.

Configuration
REQ-030 SHALL, with HAZARD_STATS_EN defined, add port StallCount  out  16: a saturating count (max 16'hFFFF) of cycles with PCWrite=0 and Rst_n=1.
REQ-031 SHALL, without HAZARD_STATS_EN, omit StallCount and its counter logic entirely.

Structure
REQ-032 SHALL take the state encoding, REG_ZERO (5'd0) and the cnt width from the shared package pipe_ctrl_pkg.
REQ-033 SHALL implement the REQ-018 comparison in a combinational sub-module load_use_detect.

Verification
REQ-034 Load-use: EX_MemRead=1, EX_rt=5, ID_rs=5 -> one cycle with PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1; next cycle EX_MemRead=0 -> normal flow.
REQ-035 Zero register: EX_MemRead=1, EX_rt=0, ID_rs=0 -> no stall; and EX_rt=7, ID_rt=7, ID_UsesRt=0 -> no stall.
REQ-036 Mul/div with MD_LATENCY=4: EX_MulDiv held high -> EX_Hold=1 for exactly 3 cycles, then 0, State returns to 0.
REQ-037 Priority: EX_Jump=1 with a simultaneous load-use match -> IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1.
REQ-038 Reset mid-MD_BUSY (cnt=1) with Rst_n=0 for one edge -> State=0, EX_Hold=0 on the following cycle.
REQ-039 HAZARD_STATS_EN: one load-use stall plus one mul/div at MD_LATENCY=4 -> StallCount=4; preloaded at 16'hFFFF, a further stall keeps it at 16'hFFFF.
